lsu_mem_access: RTL and testbench

Load/store access unit for the MEM stage of the RV32I pipeline. It sits between the pipeline and the byte-write data RAM. It accepts one byte, half or word load/store request at a time over a valid/ready handshake, and drives the RAM's enable, per-byte write-enable, word address and write-data ports. It aligns and sign- or zero-extends load data. Accesses that cross a word boundary are split into two sequential RAM accesses.

---
 rtl/lsu_mem_access.sv | 155 +++++++++++++++
 tb/tb_lsu_mem_access.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_access.sv
// rtl/lsu_mem_access.sv - RV32I MEM-stage load/store unit with split unaligned accesses
module lsu_mem_access #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int WI = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_uns;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_lo;
  logic [31:0]           r_hi;

  logic [1:0]            w_off;
  logic [7:0]            w_base;
  logic [7:0]            w_mask8;
  logic [63:0]           w_wide;
  logic                  w_split;
  logic [63:0]           w_raw64;
  logic [31:0]           w_raw;
  logic [31:0]           w_ext;
  logic [WI-1:0]         w_widx0;
  logic [WI-1:0]         w_widx1;
  logic                  w_accept;
  logic                  w_unused;

  // Address bits above the RAM range carry no meaning here.
  assign w_unused = ^req_addr[31:ADDR_WIDTH];
  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_widx0  = r_addr[ADDR_WIDTH-1:2];
  assign w_widx1  = w_widx0 + WI'(1);

  // Byte mask, lane-shifted store data and extended load data from the latched request
  always_comb begin
    w_off = r_addr[1:0];
    case (r_size)
      2'b00:   w_base = 8'h01;
      2'b01:   w_base = 8'h03;
      2'b10:   w_base = 8'h0F;
      default: w_base = 8'h00;
    endcase
    w_mask8 = w_base << w_off;
    w_wide  = {32'b0, r_wdata} << {w_off, 3'b000};
    w_split = |w_mask8[7:4];
    w_raw64 = {r_hi, r_lo} >> {w_off, 3'b000};
    w_raw   = w_raw64[31:0];
    case (r_size)
      2'b00:   w_ext = r_uns ? {24'b0, w_raw[7:0]}  : {{24{w_raw[7]}}, w_raw[7:0]};
      2'b01:   w_ext = r_uns ? {16'b0, w_raw[15:0]} : {{16{w_raw[15]}}, w_raw[15:0]};
      default: w_ext = w_raw;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = (req_size == 2'b11) ? S_RESP : S_ACC0;
      S_ACC0:  w_next = w_split ? S_ACC1 : S_RESP;
      S_ACC1:  w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch and load-word capture; hi is cleared so non-split loads see zero above lo
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_size  <= req_size;
        r_uns   <= req_unsigned;
        r_err   <= (req_size == 2'b11);
        r_addr  <= req_addr[ADDR_WIDTH-1:0];
        r_wdata <= req_wdata[31:0];
        r_hi    <= '0;
      end
      if (r_state == S_ACC0 && !r_we) r_lo <= mem_rdata[31:0];
      if (r_state == S_ACC1 && !r_we) r_hi <= mem_rdata[31:0];
    end
  end

  // Outputs decoded from state and latched request only
  always_comb begin
    req_ready = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 4'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    case (r_state)
      S_IDLE: req_ready = 1'b1;
      S_ACC0: begin
        mem_en    = 1'b1;
        mem_addr  = {w_widx0, 2'b00};
        mem_we    = r_we ? w_mask8[3:0] : 4'b0;
        mem_wdata = w_wide[31:0];
      end
      S_ACC1: begin
        mem_en    = 1'b1;
        mem_addr  = {w_widx1, 2'b00};
        mem_we    = r_we ? w_mask8[7:4] : 4'b0;
        mem_wdata = w_wide[63:32];
      end
      default: begin
        rsp_valid = 1'b1;
        rsp_err   = r_err;
        rsp_rdata = (r_we || r_err) ? '0 : w_ext;
      end
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
// tb/tb_lsu_mem_access.sv - randomized scoreboard bench for lsu_mem_access
module tb_lsu_mem_access;

  typedef struct packed {
    logic        ready;
    logic        en;
    logic [3:0]  we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        rv;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [7:0]  ram     [0:63];
  logic [7:0]  ref_mem [0:63];
  logic        clr = 1'b1;
  logic        chk_en = 1'b0;
  exp_t        exp_q[$];
  exp_t        cmp_e;
  int          tests = 0;
  int          fails = 0;
  int          negcnt = 0;
  int          acc_neg = 0;
  int          rsp_neg = 0;
  logic [31:0] last_rdata = '0;

  always #5 clk = ~clk;

  lsu_mem_access #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Byte-write RAM with combinational read
  assign mem_rdata = {ram[{mem_addr[5:2], 2'd3}], ram[{mem_addr[5:2], 2'd2}],
                      ram[{mem_addr[5:2], 2'd1}], ram[{mem_addr[5:2], 2'd0}]};

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 64; i++) ram[i] <= 8'h00;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[{mem_addr[5:2], 2'(b)}] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, want, $time);
    end
  endtask

  // Per-cycle comparison against the scoreboard queue; empty queue means idle outputs
  always @(negedge clk) begin
    negcnt++;
    if (chk_en) begin
      if (exp_q.size() > 0) cmp_e = exp_q.pop_front();
      else begin
        cmp_e = '0;
        cmp_e.ready = 1'b1;
      end
      check("req_ready", 32'(req_ready), 32'(cmp_e.ready));
      check("mem_en",    32'(mem_en),    32'(cmp_e.en));
      check("mem_we",    32'(mem_we),    32'(cmp_e.we));
      check("mem_addr",  32'(mem_addr),  32'(cmp_e.addr));
      check("mem_wdata", mem_wdata,      cmp_e.wdata);
      check("rsp_valid", 32'(rsp_valid), 32'(cmp_e.rv));
      check("rsp_rdata", rsp_rdata,      cmp_e.rdata);
      check("rsp_err",   32'(rsp_err),   32'(cmp_e.err));
      if (rsp_valid) begin
        last_rdata = rsp_rdata;
        rsp_neg    = negcnt;
      end
    end
  end

  // Reference model: enumerate the accessed bytes, derive per-cycle outputs, update memory
  task automatic push_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] ad, input logic [31:0] wd,
                          output logic [31:0] mrd, output exp_t a0, output exp_t a1);
    logic [5:0]  a;
    logic [5:0]  ba;
    logic [3:0]  w0;
    logic [31:0] val;
    exp_t        r;
    int          nb;
    int          p;
    logic        split;
    a  = ad[5:0];
    a0 = '0;
    a1 = '0;
    r  = '0;
    r.rv = 1'b1;
    if (sz == 2'b11) begin
      r.err = 1'b1;
      exp_q.push_back(r);
      mrd = 32'h0;
      return;
    end
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    w0 = a[5:2];
    a0.en = 1'b1; a0.addr = {w0, 2'b00};
    a1.en = 1'b1; a1.addr = {4'(w0 + 4'd1), 2'b00};
    for (int i = 0; i < 4; i++) begin
      p = int'(a[1:0]) + i;
      if (p < 4) a0.wdata[8*p +: 8] = wd[8*i +: 8];
      else       a1.wdata[8*(p-4) +: 8] = wd[8*i +: 8];
    end
    split = 1'b0;
    val   = '0;
    for (int i = 0; i < nb; i++) begin
      ba = a + 6'(i);
      if (ba[5:2] == w0) begin
        if (we) a0.we[ba[1:0]] = 1'b1;
      end else begin
        split = 1'b1;
        if (we) a1.we[ba[1:0]] = 1'b1;
      end
      val[8*i +: 8] = ref_mem[ba];
      if (we) ref_mem[ba] = wd[8*i +: 8];
    end
    if (nb < 4 && !uns && val[8*nb-1]) val = val | ~((32'h1 << (8*nb)) - 32'h1);
    r.rdata = we ? 32'h0 : val;
    exp_q.push_back(a0);
    if (split) exp_q.push_back(a1);
    exp_q.push_back(r);
    mrd = r.rdata;
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] ad, input logic [31:0] wd,
                        output logic [31:0] mrd, output exp_t a0, output exp_t a1,
                        output int lat);
    int k;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = ad; req_wdata = wd;
    last_rdata = 32'hBAD0BAD0;
    rsp_neg = -100;
    @(posedge clk);
    acc_neg = negcnt;
    push_req(we, sz, uns, ad, wd, mrd, a0, a1);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_addr = $urandom; req_wdata = $urandom; req_unsigned = 1'($urandom);
    k = 0;
    while (exp_q.size() > 0 && k < 10) begin
      @(negedge clk); #1;
      k++;
    end
    if (exp_q.size() > 0) begin
      check("req_timeout", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
    end
    lat = rsp_neg - acc_neg;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    exp_t a0, a1;
    int lat;
    logic [1:0] sz;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_mem_en",    32'(mem_en),    32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_mem_we",    32'(mem_we),    32'h0);
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    reset_n = 1'b1;
    chk_en = 1'b1;

    do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, r, a0, a1, lat);
    check("sw08_acc0_addr", 32'(a0.addr), 32'h08);
    check("sw08_acc0_we",   32'(a0.we),   32'hF);
    check("sw08_acc0_wd",   a0.wdata,     32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, r, a0, a1, lat);
    check("lw08_model", r, 32'hDEADBEEF);
    check("lw08_dut",   last_rdata, 32'hDEADBEEF);
    check("lw08_lat",   32'(lat), 32'd2);

    do_req(1'b1, 2'b00, 1'b0, 32'h09, 32'h000000A5, r, a0, a1, lat);
    check("sb09_we", 32'(a0.we), 32'h2);
    check("sb09_wd", a0.wdata,   32'h0000A500);
    do_req(1'b0, 2'b00, 1'b0, 32'h09, 32'h0, r, a0, a1, lat);
    check("lb09_dut", last_rdata, 32'hFFFFFFA5);
    do_req(1'b0, 2'b00, 1'b1, 32'h09, 32'h0, r, a0, a1, lat);
    check("lbu09_dut", last_rdata, 32'h000000A5);
    do_req(1'b0, 2'b01, 1'b1, 32'h08, 32'h0, r, a0, a1, lat);
    check("lhu08_dut", last_rdata, 32'h0000A5EF);

    do_req(1'b1, 2'b10, 1'b0, 32'h06, 32'h11223344, r, a0, a1, lat);
    check("sw06_acc0_addr", 32'(a0.addr), 32'h04);
    check("sw06_acc0_we",   32'(a0.we),   32'hC);
    check("sw06_acc0_wd",   a0.wdata,     32'h33440000);
    check("sw06_acc1_addr", 32'(a1.addr), 32'h08);
    check("sw06_acc1_we",   32'(a1.we),   32'h3);
    check("sw06_acc1_wd",   a1.wdata,     32'h00001122);
    do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, r, a0, a1, lat);
    check("lw06_dut", last_rdata, 32'h11223344);
    check("lw06_lat", 32'(lat), 32'd3);

    do_req(1'b1, 2'b01, 1'b0, 32'h3F, 32'h0000BEEF, r, a0, a1, lat);
    check("sh3f_acc0_addr", 32'(a0.addr), 32'h3C);
    check("sh3f_acc0_we",   32'(a0.we),   32'h8);
    check("sh3f_acc1_addr", 32'(a1.addr), 32'h00);
    check("sh3f_acc1_we",   32'(a1.we),   32'h1);
    do_req(1'b0, 2'b01, 1'b0, 32'h3F, 32'h0, r, a0, a1, lat);
    check("lh3f_dut", last_rdata, 32'hFFFFBEEF);

    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h12345678, r, a0, a1, lat);
    check("err_dut_rdata", last_rdata, 32'h0);
    check("err_lat", 32'(lat), 32'd1);

    // Reset during the second half of a split store
    do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'h0, r, a0, a1, lat);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h06; req_wdata = 32'hAABBCCDD;
    chk_en = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_acc1_en",   32'(mem_en),   32'h1);
    check("rst_mid_acc1_addr", 32'(mem_addr), 32'h08);
    reset_n = 1'b0;
    #1;
    check("rst_mid_mem_we",    32'(mem_we),    32'h0);
    check("rst_mid_mem_en",    32'(mem_en),    32'h0);
    check("rst_mid_rsp_valid", 32'(rsp_valid), 32'h0);
    exp_q.delete();
    ref_mem[6] = 8'hDD;
    ref_mem[7] = 8'hCC;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("rst_rel_ready", 32'(req_ready), 32'h1);
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, r, a0, a1, lat);
    check("rst_lw08_dut", last_rdata, 32'h00000000);
    do_req(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, r, a0, a1, lat);
    check("rst_lw04_dut", last_rdata, 32'hCCDD0000);

    for (int n = 0; n < 300; n++) begin
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      do_req(1'($urandom), sz, 1'($urandom), $urandom, $urandom, r, a0, a1, lat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    @(posedge clk); #1;
    for (int w = 0; w < 16; w++)
      check("ram_final",
            {ram[4*w+3], ram[4*w+2], ram[4*w+1], ram[4*w]},
            {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
